// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by fetch_queue and fetch_unit.
package fetch_unit_pkg;

   localparam int                 INSTR_W   = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      FULL = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction ROM port plus the decode-side handshake.
// master = fetch unit, slave = ROM/decode side.
interface fetch_unit_if #(parameter int ADDR_W = 8);
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;
   logic              stall;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              inst_valid;
   logic [31:0]       inst_out;
   logic [31:0]       pc_out;
   logic [31:0]       pc_plus4;

   modport master (
      output imem_addr, inst_valid, inst_out, pc_out, pc_plus4,
      input  imem_data, stall, redirect, redirect_pc
   );

   modport slave (
      input  imem_addr, inst_valid, inst_out, pc_out, pc_plus4,
      output imem_data, stall, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous {pc,instr} FIFO with push, pop and flush; flush wins over both.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_queue
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  fetch_entry_t             din,
   output fetch_entry_t             head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t [DEPTH-1:0] mem;
   logic [PTR_W:0]           wr_ptr, rd_ptr;
   logic                     do_push, do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign count = wr_ptr - rd_ptr;

   // A push into a full queue is only taken when the head leaves in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[PTR_W-1:0]] <= din;
   end

   assign head = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and queues
// fetched {pc,instr} pairs for decode. FETCH_PERF_CNT_EN adds stall/flush counters.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int          ADDR_W   = 8,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic          clk,
   input  logic          reset_n,
   fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]   stall_cnt,
   output logic [15:0]   flush_cnt
`endif
);

   localparam int               PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   LAST  = (PTR_W+1)'(DEPTH-1);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         push, pop, flush;
   fetch_entry_t q_din, q_head;
   logic         q_empty, q_full;
   logic [PTR_W:0] q_count;

   assign pop   = ~q_empty & ~bus.stall;
   assign flush = bus.redirect;
   assign q_din = '{pc: pc_q, instr: bus.imem_data};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Redirect overrides everything, including the boot bubble.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      push    = 1'b0;
      if (bus.redirect) begin
         state_d = RUN;
         pc_d    = bus.redirect_pc;
      end else begin
         case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
               push = 1'b1;
               pc_d = pc_q + 32'd4;
               if (!pop && q_count == LAST) state_d = FULL;
            end
            FULL: if (pop) state_d = RUN;
            default: state_d = BOOT;
         endcase
      end
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .push    (push),
      .pop     (pop),
      .din     (q_din),
      .head    (q_head),
      .empty   (q_empty),
      .full    (q_full),
      .count   (q_count)
   );

   // Head fields read as NOP/zero while empty so reset clears them without an edge.
   assign bus.imem_addr  = pc_q[ADDR_W-1:0];
   assign bus.inst_valid = ~q_empty;
   assign bus.inst_out   = q_empty ? NOP_INSTR : q_head.instr;
   assign bus.pc_out     = q_empty ? 32'h0 : q_head.pc;
   assign bus.pc_plus4   = bus.pc_out + 32'd4;

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (~q_empty && bus.stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
         if (bus.redirect && flush_cnt != 16'hFFFF)          flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule
